// File: rtl/i2c_defs.sv
// Shared I2C constants: R/W bit values, register-sequencer state encoding and
// the address-byte builder used wherever a slave address goes on the wire.
package i2c_defs;

  localparam logic I2C_BIT_WR = 1'b0;
  localparam logic I2C_BIT_RD = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_ADDRW  = 4'd1,
    ST_REG    = 4'd2,
    ST_WDATA  = 4'd3,
    ST_RSTART = 4'd4,
    ST_ADDRR  = 4'd5,
    ST_RDATA  = 4'd6,
    ST_STOP   = 4'd7,
    ST_DONE   = 4'd8
  } seq_state_e;

  // R/W flag sits in bit 0, below the 7-bit address.
  function automatic logic [7:0] addr_byte(input logic [6:0] addr, input logic rw);
    return {addr, rw};
  endfunction

endpackage

// File: rtl/i2c_regseq.sv
// Register-transaction sequencer: expands one register read/write command into
// the byte requests of a byte-wise I2C master, streaming data in and out.
module i2c_regseq
  import i2c_defs::*;
#(
  parameter int LGLEN   = 4,
  parameter int TIMEOUT = 2**20
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cmd_stb,
  input  logic             i_cmd_rd,
  input  logic [6:0]       i_cmd_addr,
  input  logic [7:0]       i_cmd_reg,
  input  logic [LGLEN-1:0] i_cmd_len,
  output logic             o_cmd_busy,
  input  logic             i_wr_valid,
  input  logic [7:0]       i_wr_data,
  output logic             o_wr_ready,
  output logic             o_rd_valid,
  output logic [7:0]       o_rd_data,
  output logic             o_done,
  output logic             o_err,
  output logic             o_ll_cyc,
  output logic             o_ll_stb,
  output logic             o_ll_we,
  output logic [7:0]       o_ll_data,
  input  logic             i_ll_ack,
  input  logic             i_ll_busy,
  input  logic             i_ll_err,
  input  logic [7:0]       i_ll_data,
  output logic [3:0]       o_dbg_state
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  // Master handshake: a byte is taken on a clock where stb is high and the
  // master is not busy; stb then drops and exactly one byte is outstanding
  // (sent_q) until the master acks it. Write data is consumed on a clock where
  // o_wr_ready is high, which only happens when i_wr_valid is also high.

  seq_state_e       state_q, state_d;
  logic             cyc_q, cyc_d;
  logic             stb_q, stb_d;
  logic             we_q, we_d;
  logic [7:0]       data_q, data_d;
  logic             sent_q, sent_d;
  logic             rd_q, rd_d;
  logic [6:0]       addr_q, addr_d;
  logic [7:0]       reg_q, reg_d;
  logic [LGLEN-1:0] cnt_q, cnt_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             err_q, err_d;
  logic             rd_valid_q, rd_valid_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             wr_ready;
  logic             active;
  logic             ack;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      data_q     <= 8'h00;
      sent_q     <= 1'b0;
      rd_q       <= 1'b0;
      addr_q     <= 7'h00;
      reg_q      <= 8'h00;
      cnt_q      <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      data_q     <= data_d;
      sent_q     <= sent_d;
      rd_q       <= rd_d;
      addr_q     <= addr_d;
      reg_q      <= reg_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    we_d       = we_q;
    data_d     = data_q;
    sent_d     = sent_q;
    rd_d       = rd_q;
    addr_d     = addr_q;
    reg_d      = reg_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    wr_ready   = 1'b0;

    active = (state_q == ST_ADDRW) || (state_q == ST_REG) || (state_q == ST_WDATA) ||
             (state_q == ST_ADDRR) || (state_q == ST_RDATA);
    ack    = sent_q && i_ll_ack;
    // Timer restarts on every ack; states outside the byte phases hold it at zero,
    // so every state entry also starts from zero.
    tmo_d  = (active && !ack) ? tmo_q + 1'b1 : '0;

    if (stb_q && !i_ll_busy) begin
      stb_d  = 1'b0;
      sent_d = 1'b1;
    end
    if (ack) begin
      sent_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_cmd_stb) begin
          rd_d    = i_cmd_rd;
          addr_d  = i_cmd_addr;
          reg_d   = i_cmd_reg;
          cnt_d   = i_cmd_len;
          err_d   = 1'b0;
          sent_d  = 1'b0;
          state_d = ST_ADDRW;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          we_d    = 1'b1;
          data_d  = addr_byte(i_cmd_addr, I2C_BIT_WR);
        end
      end
      ST_ADDRW: begin
        if (ack) begin
          state_d = ST_REG;
          stb_d   = 1'b1;
          data_d  = reg_q;
        end
      end
      ST_REG: begin
        if (ack) begin
          if (cnt_q == '0) begin
            state_d = ST_STOP;
            cyc_d   = 1'b0;
          end else if (rd_q) begin
            state_d = ST_RSTART;
            cyc_d   = 1'b0;
          end else begin
            state_d = ST_WDATA;
          end
        end
      end
      ST_WDATA: begin
        if (!sent_q && !stb_q && i_wr_valid) begin
          wr_ready = 1'b1;
          stb_d    = 1'b1;
          data_d   = i_wr_data;
        end
        if (ack) begin
          cnt_d = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
          if (cnt_q <= LGLEN'(1)) begin
            state_d = ST_STOP;
            cyc_d   = 1'b0;
          end
        end
      end
      ST_RSTART: begin
        state_d = ST_ADDRR;
        cyc_d   = 1'b1;
        stb_d   = 1'b1;
        we_d    = 1'b1;
        data_d  = addr_byte(addr_q, I2C_BIT_RD);
      end
      ST_ADDRR: begin
        if (ack) begin
          state_d = ST_RDATA;
          stb_d   = 1'b1;
          we_d    = 1'b0;
          data_d  = 8'h00;
        end
      end
      ST_RDATA: begin
        if (ack) begin
          rd_valid_d = 1'b1;
          rd_data_d  = i_ll_data;
          cnt_d      = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
          if (cnt_q <= LGLEN'(1)) begin
            state_d = ST_STOP;
            cyc_d   = 1'b0;
          end else begin
            stb_d = 1'b1;
          end
        end
      end
      ST_STOP: begin
        cyc_d = 1'b0;
        stb_d = 1'b0;
        if (!i_ll_busy) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
      end
    endcase

    // Any failure abandons the command at once; the master sees cyc drop and stops.
    if ((ack && i_ll_err) || (active && tmo_q == TMO_LAST)) begin
      state_d    = ST_STOP;
      cyc_d      = 1'b0;
      stb_d      = 1'b0;
      sent_d     = 1'b0;
      err_d      = 1'b1;
      rd_valid_d = 1'b0;
      wr_ready   = 1'b0;
    end
  end

  assign o_cmd_busy  = (state_q != ST_IDLE);
  assign o_done      = (state_q == ST_DONE);
  assign o_err       = (state_q == ST_DONE) && err_q;
  assign o_wr_ready  = wr_ready;
  assign o_rd_valid  = rd_valid_q;
  assign o_rd_data   = rd_data_q;
  assign o_ll_cyc    = cyc_q;
  assign o_ll_stb    = stb_q;
  assign o_ll_we     = we_q;
  assign o_ll_data   = data_q;
  assign o_dbg_state = state_q;

endmodule
